// File: rtl/uart_tx_controller.sv
// uart_tx_controller
//   Transmit half of the AXI-Lite UART core. Bytes written by the register
//   block are queued in a small FIFO. Each byte is then sent on TX as a frame:
//   a start bit, the data bits LSB-first, an optional parity bit and one stop
//   bit. When the FIFO still holds data at the end of a stop bit, the next
//   frame starts on the following cycle, so there is no idle gap.
//
// Ports
//   S_AXI_ACLK     clock
//   S_AXI_ARESETN  synchronous active-low reset
//   tx_data        byte to enqueue (sampled only on accepted writes)
//   tx_wr_en       enqueue strobe, one entry per cycle
//   tx_fifo_clr    flush the FIFO; a frame already on the line finishes
//   tx_fifo_full   FIFO holds C_FIFO_DEPTH entries
//   tx_fifo_empty  FIFO holds no entries
//   tx_overflow    one-cycle pulse: a write was dropped because FIFO was full
//   tx_busy        a frame is on the line
//   tx_done        one-cycle pulse on the last cycle of each stop bit
//   TX             serial line, idle high
module uart_tx_controller #(
    parameter int C_S_AXI_ACLK_FREQ_HZ = 100_000_000,
    parameter int C_BAUDRATE           = 9600,
    parameter int C_DATA_BITS          = 8,
    parameter int C_USE_PARITY         = 0,
    parameter int C_ODD_PARITY         = 0,
    parameter int C_FIFO_DEPTH         = 16
) (
    input  logic                   S_AXI_ACLK,
    input  logic                   S_AXI_ARESETN,
    input  logic [C_DATA_BITS-1:0] tx_data,
    input  logic                   tx_wr_en,
    input  logic                   tx_fifo_clr,
    output logic                   tx_fifo_full,
    output logic                   tx_fifo_empty,
    output logic                   tx_overflow,
    output logic                   tx_busy,
    output logic                   tx_done,
    output logic                   TX
);

    localparam int CLKS_PER_BIT = C_S_AXI_ACLK_FREQ_HZ / C_BAUDRATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = $clog2(C_FIFO_DEPTH);

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(C_DATA_BITS - 1);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(C_FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // ---------------- FIFO ----------------
    logic [C_DATA_BITS-1:0] mem [C_FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [PTR_W:0]         count, count_n;
    logic                   wr_acc, pop;
    logic [C_DATA_BITS-1:0] head;

    // Clear beats a same-cycle write; the full check uses the registered flag,
    // so a write while full is dropped even if a pop frees a slot this cycle.
    assign wr_acc = tx_wr_en && !tx_fifo_full && !tx_fifo_clr;
    assign head   = mem[rd_ptr];

    always_comb begin
        count_n = count;
        if (tx_fifo_clr)
            count_n = '0;
        else if (wr_acc && !pop)
            count_n = count + (PTR_W+1)'(1);
        else if (!wr_acc && pop)
            count_n = count - (PTR_W+1)'(1);
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            tx_fifo_full  <= 1'b0;
            tx_fifo_empty <= 1'b1;
            tx_overflow   <= 1'b0;
        end else begin
            if (tx_fifo_clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count         <= count_n;
            tx_fifo_full  <= (count_n == DEPTH_CNT);
            tx_fifo_empty <= (count_n == '0);
            tx_overflow   <= tx_wr_en && tx_fifo_full;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (wr_acc) mem[wr_ptr] <= tx_data;
    end

    // ---------------- Frame FSM ----------------
    state_t                 state, state_n;
    logic [CNT_W-1:0]       baud_cnt, cnt_n;
    logic [2:0]             bit_idx, bit_idx_n;
    logic [C_DATA_BITS-1:0] shift, shift_n;
    logic                   par, par_n;
    logic                   tx_n, done_n, bit_end, can_pop, load;

    // A pending clear must not hand the old head to the line.
    assign can_pop = !tx_fifo_empty && !tx_fifo_clr;
    assign bit_end = (baud_cnt == LAST_CNT);

    always_comb begin
        state_n   = state;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        par_n     = par;
        load      = 1'b0;
        case (state)
            IDLE:   if (can_pop) load = 1'b1;
            START:  if (bit_end) begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                    end
            DATA:   if (bit_end) begin
                        shift_n   = shift >> 1;
                        bit_idx_n = bit_idx + 3'd1;
                        if (bit_idx == LAST_BIT)
                            state_n = (C_USE_PARITY != 0) ? PARITY : STOP;
                    end
            PARITY: if (bit_end) state_n = STOP;
            STOP:   if (bit_end) begin
                        if (can_pop) load = 1'b1;
                        else         state_n = IDLE;
                    end
            default: state_n = IDLE;
        endcase

        pop = load;
        if (load) begin
            state_n = START;
            shift_n = head;
            par_n   = (^head) ^ (C_ODD_PARITY != 0);
        end

        // Counter restarts on every state change and at every bit boundary.
        if (state_n != state || bit_end || state == IDLE)
            cnt_n = '0;
        else
            cnt_n = baud_cnt + CNT_W'(1);

        // Line level is computed from the next state so TX comes from a flop.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PARITY:  tx_n = par_n;
            default: tx_n = 1'b1;
        endcase
        done_n = (state_n == STOP) && (cnt_n == LAST_CNT);
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            par      <= 1'b0;
            TX       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= cnt_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            par      <= par_n;
            TX       <= tx_n;
            tx_busy  <= (state_n != IDLE);
            tx_done  <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_controller.sv
module tb_uart_tx_controller;

    localparam int CPB    = 10;
    localparam int FRAME  = 100;
    localparam int PFRAME = 110;

    logic       clk = 1'b0;
    logic       rst_n, wr, clr, pwr;
    logic [7:0] tx_data;
    logic       full, empty, ovf, busy, done, tx;
    logic       o_full, o_empty, o_ovf, o_busy, o_done, o_tx;
    logic       e_full, e_empty, e_ovf, e_busy, e_done, e_tx;

    always #5 clk = ~clk;

    uart_tx_controller #(.C_S_AXI_ACLK_FREQ_HZ(1_000_000), .C_BAUDRATE(100_000)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .tx_data(tx_data), .tx_wr_en(wr),
        .tx_fifo_clr(clr), .tx_fifo_full(full), .tx_fifo_empty(empty),
        .tx_overflow(ovf), .tx_busy(busy), .tx_done(done), .TX(tx));

    uart_tx_controller #(.C_S_AXI_ACLK_FREQ_HZ(1_000_000), .C_BAUDRATE(100_000),
                         .C_USE_PARITY(1), .C_ODD_PARITY(1)) dut_odd (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .tx_data(tx_data), .tx_wr_en(pwr),
        .tx_fifo_clr(1'b0), .tx_fifo_full(o_full), .tx_fifo_empty(o_empty),
        .tx_overflow(o_ovf), .tx_busy(o_busy), .tx_done(o_done), .TX(o_tx));

    uart_tx_controller #(.C_S_AXI_ACLK_FREQ_HZ(1_000_000), .C_BAUDRATE(100_000),
                         .C_USE_PARITY(1), .C_ODD_PARITY(0)) dut_even (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .tx_data(tx_data), .tx_wr_en(pwr),
        .tx_fifo_clr(1'b0), .tx_fifo_full(e_full), .tx_fifo_empty(e_empty),
        .tx_overflow(e_ovf), .tx_busy(e_busy), .tx_done(e_done), .TX(e_tx));

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic tx_of(input int sel);
        case (sel)
            1:       return o_tx;
            2:       return e_tx;
            default: return tx;
        endcase
    endfunction

    function automatic logic done_of(input int sel);
        case (sel)
            1:       return o_done;
            2:       return e_done;
            default: return done;
        endcase
    endfunction

    // Reference parity: the bit that makes the total count of ones even/odd.
    function automatic logic exp_par(input logic [7:0] b, input bit odd);
        bit ones_odd;
        ones_odd = ($countones(b) % 2) == 1;
        return odd ? !ones_odd : ones_odd;
    endfunction

    // Line receiver: waits for a start edge, samples every bit mid-period,
    // and checks start/stop levels and that tx_done fires only on the last cycle.
    task automatic capture(input int sel, input int total, output logic [7:0] data,
                           output logic par, output int fall_cyc, output bit ok);
        int t, ndone, nb;
        logic [10:0] bits;
        bit last_done;
        ok = 0; t = 0; data = 'x; par = 'x; fall_cyc = 0;
        do begin
            @(negedge clk);
            t++;
        end while (tx_of(sel) !== 1'b0 && t < 400);
        if (tx_of(sel) !== 1'b0) begin
            n_cmp++; n_err++;
            $display("FAIL capture_timeout sel=%0d: no start bit within 400 cycles", sel);
            return;
        end
        fall_cyc = cyc; ndone = 0; bits = '0; last_done = 0;
        for (int o = 0; o < total; o++) begin
            if (o > 0) @(negedge clk);
            if (o % CPB == CPB / 2) bits[o / CPB] = tx_of(sel);
            if (done_of(sel) === 1'b1) begin
                ndone++;
                if (o == total - 1) last_done = 1;
            end
        end
        nb = total / CPB;
        n_cmp++;
        if (bits[0] !== 1'b0) begin n_err++; $display("FAIL start_bit sel=%0d: got %b want 0", sel, bits[0]); end
        n_cmp++;
        if (bits[nb-1] !== 1'b1) begin n_err++; $display("FAIL stop_bit sel=%0d: got %b want 1", sel, bits[nb-1]); end
        n_cmp++;
        if (ndone != 1 || !last_done) begin
            n_err++;
            $display("FAIL done_pulse sel=%0d: %0d pulses, on last cycle=%0d, want 1 pulse on last cycle", sel, ndone, last_done);
        end
        data = bits[8:1];
        par  = bits[9];
        ok   = 1;
    endtask

    task automatic test_reset;
        logic [5:0] got;
        string names [6] = '{"full", "empty", "overflow", "done", "busy", "tx"};
        rst_n = 1'b0; wr = 1'b0; clr = 1'b0; pwr = 1'b0; tx_data = '0;
        repeat (3) @(negedge clk);
        for (int pass = 0; pass < 2; pass++) begin
            got = {tx, busy, done, ovf, empty, full};
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (got[i] !== 6'b100010 >> i & 6'b1) begin end
            end
            n_cmp++;
            if (got !== 6'b100010) begin
                n_err++;
                for (int i = 0; i < 6; i++)
                    if (got[i] !== ((6'b100010 >> i) & 6'b1) != 0)
                        $display("FAIL reset_%s pass=%0d: got %b want %b", names[i], pass, got[i], ((6'b100010 >> i) & 6'b1) != 0);
            end
            rst_n = 1'b1;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_single;
        logic [7:0] d; logic p; int fc; bit ok;
        fork
            begin
                tx_data = 8'h55; wr = 1'b1;
                @(negedge clk);
                wr = 1'b0;
                n_cmp++;
                if (empty !== 1'b0 || tx !== 1'b1) begin
                    n_err++; $display("FAIL single_accept: empty=%b tx=%b want empty=0 tx=1", empty, tx);
                end
                @(negedge clk);
                n_cmp++;
                if (tx !== 1'b0 || busy !== 1'b1) begin
                    n_err++; $display("FAIL single_latency: tx=%b busy=%b want tx=0 busy=1", tx, busy);
                end
                repeat (40) begin
                    tx_data = 8'($urandom);
                    @(negedge clk);
                end
            end
            capture(0, FRAME, d, p, fc, ok);
        join
        n_cmp++;
        if (!ok || d !== 8'h55) begin n_err++; $display("FAIL single_data: got %h want 55", d); end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            n_err++; $display("FAIL single_idle: busy=%b tx=%b want busy=0 tx=1", busy, tx);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] b0, b1, d0, d1; logic p; int f0, f1; bit ok0, ok1;
        for (int r = 0; r < 2; r++) begin
            b0 = (r == 0) ? 8'hA3 : 8'($urandom);
            b1 = (r == 0) ? 8'h0F : 8'($urandom);
            fork
                begin
                    tx_data = b0; wr = 1'b1;
                    @(negedge clk);
                    tx_data = b1;
                    @(negedge clk);
                    wr = 1'b0;
                end
                begin
                    capture(0, FRAME, d0, p, f0, ok0);
                    capture(0, FRAME, d1, p, f1, ok1);
                end
            join
            n_cmp++;
            if (!ok0 || d0 !== b0) begin n_err++; $display("FAIL b2b_first r=%0d: got %h want %h", r, d0, b0); end
            n_cmp++;
            if (!ok1 || d1 !== b1) begin n_err++; $display("FAIL b2b_second r=%0d: got %h want %h", r, d1, b1); end
            n_cmp++;
            if (f1 - f0 != FRAME) begin n_err++; $display("FAIL b2b_gap r=%0d: got %0d want %0d", r, f1 - f0, FRAME); end
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle r=%0d: busy=%b want 0", r, busy); end
        end
    endtask

    task automatic test_full;
        logic [7:0] wb [18];
        logic [7:0] exp_q [$];
        bit exp_full [18];
        bit exp_ovf [18];
        int occ, prev_fc, fc;
        logic [7:0] d; logic p; bit ok, acc, stray;
        // Occupancy model: registered full gates writes; the first byte leaves
        // the FIFO one cycle after it is accepted, and no other frame starts
        // during the 18-cycle burst.
        occ = 0;
        for (int k = 0; k < 18; k++) begin
            wb[k] = 8'($urandom);
            acc = (occ < 16);
            if (acc) begin exp_q.push_back(wb[k]); occ++; end
            if (k == 1) occ--;
            exp_full[k] = (occ == 16);
            exp_ovf[k]  = !acc;
        end
        fork
            begin
                for (int k = 0; k < 18; k++) begin
                    tx_data = wb[k]; wr = 1'b1;
                    @(negedge clk);
                    n_cmp++;
                    if (full !== exp_full[k] || ovf !== exp_ovf[k]) begin
                        n_err++;
                        $display("FAIL full_flags k=%0d: full=%b ovf=%b want full=%b ovf=%b", k, full, ovf, exp_full[k], exp_ovf[k]);
                    end
                end
                wr = 1'b0;
                @(negedge clk);
                n_cmp++;
                if (ovf !== 1'b0) begin n_err++; $display("FAIL overflow_width: ovf=%b want 0", ovf); end
            end
            begin
                prev_fc = 0;
                for (int f = 0; f < exp_q.size(); f++) begin
                    capture(0, FRAME, d, p, fc, ok);
                    n_cmp++;
                    if (!ok || d !== exp_q[f]) begin n_err++; $display("FAIL full_frame f=%0d: got %h want %h", f, d, exp_q[f]); end
                    if (f > 0) begin
                        n_cmp++;
                        if (fc - prev_fc != FRAME) begin n_err++; $display("FAIL full_gap f=%0d: got %0d want %0d", f, fc - prev_fc, FRAME); end
                    end
                    prev_fc = fc;
                end
            end
        join
        stray = 0;
        repeat (150) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || empty !== 1'b1) stray = 1;
        end
        n_cmp++;
        if (stray) begin n_err++; $display("FAIL full_extra_frame: line active after %0d frames, want idle", exp_q.size()); end
    endtask

    task automatic test_parity;
        logic [7:0] b, d1, d2; logic p1, p2; int f1, f2; bit ok1, ok2;
        for (int r = 0; r < 3; r++) begin
            b = (r == 0) ? 8'h07 : 8'($urandom);
            fork
                begin
                    tx_data = b; pwr = 1'b1;
                    @(negedge clk);
                    pwr = 1'b0;
                end
                capture(1, PFRAME, d1, p1, f1, ok1);
                capture(2, PFRAME, d2, p2, f2, ok2);
            join
            n_cmp++;
            if (!ok1 || d1 !== b || p1 !== exp_par(b, 1)) begin
                n_err++; $display("FAIL parity_odd r=%0d: data=%h par=%b want data=%h par=%b", r, d1, p1, b, exp_par(b, 1));
            end
            n_cmp++;
            if (!ok2 || d2 !== b || p2 !== exp_par(b, 0)) begin
                n_err++; $display("FAIL parity_even r=%0d: data=%h par=%b want data=%h par=%b", r, d2, p2, b, exp_par(b, 0));
            end
            @(negedge clk);
        end
    endtask

    // Queues four bytes: the first goes straight to the line, three wait.
    // Returns at the negedge two cycles after the start bit appeared.
    task automatic queue_four(output logic [7:0] b0);
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            if (k == 0) b0 = b;
            tx_data = b; wr = 1'b1;
            @(negedge clk);
            if (k == 1) begin
                n_cmp++;
                if (tx !== 1'b0) begin n_err++; $display("FAIL queue_start: tx=%b want 0", tx); end
            end
        end
        wr = 1'b0;
    endtask

    task automatic test_fifo_clr;
        logic [7:0] b0; int ndone; bit last_done, stray;
        queue_four(b0);
        repeat (18) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_cmp++;
        if (empty !== 1'b1 || busy !== 1'b1 || tx !== b0[1]) begin
            n_err++; $display("FAIL clr_state: empty=%b busy=%b tx=%b want empty=1 busy=1 tx=%b", empty, busy, tx, b0[1]);
        end
        ndone = 0; last_done = 0;
        for (int o = 22; o < FRAME; o++) begin
            @(negedge clk);
            if (done === 1'b1) begin ndone++; if (o == FRAME - 1) last_done = 1; end
        end
        n_cmp++;
        if (ndone != 1 || !last_done) begin n_err++; $display("FAIL clr_frame_done: %0d pulses, last=%0d, want 1 on last cycle", ndone, last_done); end
        stray = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1 || done !== 1'b0 || busy !== 1'b0) stray = 1;
        end
        n_cmp++;
        if (stray || empty !== 1'b1) begin n_err++; $display("FAIL clr_no_more_frames: stray=%0d empty=%b want 0/1", stray, empty); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b0; bit stray;
        queue_four(b0);
        repeat (33) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (tx !== 1'b1 || empty !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_state: tx=%b empty=%b busy=%b done=%b want 1 1 0 0", tx, empty, busy, done);
        end
        rst_n = 1'b1;
        stray = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1 || done !== 1'b0 || busy !== 1'b0) stray = 1;
        end
        n_cmp++;
        if (stray) begin n_err++; $display("FAIL rst_mid_resumed: line active after reset, want idle"); end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_parity();
        test_fifo_clr();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
